contador_palabras: RTL and testbench

- Responder side of the word-count read interface driven by the bench during IDLE.
- Counts words actually popped from each of the 4 output FIFOs (FIFO4..FIFO7).
- Returns the selected count on a req/idx request, with a registered valid_contador/contador_out response.
- Sits beside the output FIFOs. It taps their pop and empty signals and does not modify the data path.

---
 rtl/contador_palabras.sv | 71 +++++++
 tb/tb_contador_palabras.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/contador_palabras.sv
// Word counter for output FIFOs 4..7, answering registered idx reads while the main FSM is IDLE.
// Optional CONTADOR_CLR_ON_READ_EN: the counter selected by an accepted read clears as it is captured.
module contador_palabras #(
  parameter int CNT_W  = 5,
  parameter int N_FIFO = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pop4,
  input  logic             pop5,
  input  logic             pop6,
  input  logic             pop7,
  input  logic             empty4,
  input  logic             empty5,
  input  logic             empty6,
  input  logic             empty7,
  input  logic             IDLE,
  input  logic             req,
  input  logic [1:0]       idx,
  output logic             valid_contador,
  output logic [CNT_W-1:0] contador_out
);

  typedef enum logic {ESPERA, RESPONDE} estado_t;

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q [N_FIFO];
  logic [CNT_W-1:0] cnt_d [N_FIFO];
  logic [CNT_W-1:0] out_q, out_d;
  logic [N_FIFO-1:0] pop, empty;
  logic             rd_acc;

  assign pop   = {pop7, pop6, pop5, pop4};
  assign empty = {empty7, empty6, empty5, empty4};

  always_comb begin
    rd_acc = IDLE & req;
    for (int i = 0; i < N_FIFO; i++) begin
      cnt_d[i] = cnt_q[i];
      // Saturate at all-ones; a pop on an empty FIFO moves no word.
      if (pop[i] && !empty[i] && (cnt_q[i] != '1))
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
    estado_d = rd_acc ? RESPONDE : ESPERA;
    out_d    = out_q;
    if (rd_acc)
      out_d = cnt_d[idx];
`ifdef CONTADOR_CLR_ON_READ_EN
    if (rd_acc)
      cnt_d[idx] = '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= ESPERA;
      out_q    <= '0;
      for (int i = 0; i < N_FIFO; i++)
        cnt_q[i] <= '0;
    end else begin
      estado_q <= estado_d;
      out_q    <= out_d;
      for (int i = 0; i < N_FIFO; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign valid_contador = (estado_q == RESPONDE);
  assign contador_out   = out_q;

endmodule

// File: tb/tb_contador_palabras.sv
// Scoreboard bench for contador_palabras: reads push expected counts, a negedge monitor pops and compares.
module tb_contador_palabras;

  localparam int CNT_W = 5;

  logic             clk;
  logic             reset;
  logic [3:0]       pop, empty;
  logic             IDLE, req;
  logic [1:0]       idx;
  logic             valid_contador;
  logic [CNT_W-1:0] contador_out;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];

`ifdef CONTADOR_CLR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  contador_palabras #(.CNT_W(CNT_W), .N_FIFO(4)) dut (
    .clk(clk), .reset(reset),
    .pop4(pop[0]), .pop5(pop[1]), .pop6(pop[2]), .pop7(pop[3]),
    .empty4(empty[0]), .empty5(empty[1]), .empty6(empty[2]), .empty7(empty[3]),
    .IDLE(IDLE), .req(req), .idx(idx),
    .valid_contador(valid_contador), .contador_out(contador_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Response monitor: every valid cycle must match the oldest expected value.
  initial begin
    forever begin
      @(negedge clk);
      if (valid_contador === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_resp: got contador_out=%0d, expected no response", contador_out);
        end else begin
          check("resp", int'(contador_out), exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    IDLE = 1'b0; req = 1'b0; pop = '0; empty = '0;
    tick();
  endtask

  task automatic pop_n(input int f, input int n, input bit emp);
    for (int k = 0; k < n; k++) begin
      pop[f] = 1'b1; empty[f] = emp;
      tick();
    end
    pop = '0; empty = '0;
  endtask

  task automatic rd(input int i, input int exp);
    IDLE = 1'b1; req = 1'b1; idx = 2'(i);
    exp_q.push_back(exp);
    tick();
  endtask

  task automatic do_reset();
    idle_cyc();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; pop = '0; empty = '0; IDLE = 1'b0; req = 1'b0; idx = '0;
    #12;
    check("rst_valid", int'(valid_contador), 0);
    check("rst_out", int'(contador_out), 0);
    tick();
    reset = 1'b0;
    tick();

    // Reset landing in the middle of a response.
    pop_n(0, 3, 1'b0);
    IDLE = 1'b1; req = 1'b1; idx = 2'd0;
    tick();
    check("valid_before_rst", int'(valid_contador), 1);
    check("out_before_rst", int'(contador_out), 3);
    reset = 1'b1;
    #1;
    check("midresp_rst_valid", int'(valid_contador), 0);
    check("midresp_rst_out", int'(contador_out), 0);
    IDLE = 1'b0; req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) rd(i, 0);
    idle_cyc();

    // Four pops on every FIFO, then back-to-back reads.
    do_reset();
    pop = 4'hF; empty = '0;
    repeat (4) tick();
    pop = '0;
    for (int i = 0; i < 4; i++) rd(i, 4);
    idle_cyc();

    // Pops on an empty FIFO are not counted.
    do_reset();
    pop_n(1, 2, 1'b1);
    pop_n(1, 3, 1'b0);
    rd(1, 3);
    idle_cyc();

    // Saturation, and an untouched neighbour stays at zero.
    do_reset();
    pop_n(2, 40, 1'b0);
    rd(2, 31);
    rd(3, 0);
    idle_cyc();

    // Requests outside IDLE are ignored.
    do_reset();
    IDLE = 1'b0; req = 1'b1; idx = 2'd3;
    tick();
    check("gated_valid_0", int'(valid_contador), 0);
    tick();
    check("gated_valid_1", int'(valid_contador), 0);

    // Request coincident with a pop returns the updated count.
    pop_n(3, 7, 1'b0);
    pop[3] = 1'b1; empty[3] = 1'b0;
    rd(3, 8);
    pop = '0;
    rd(3, CLR ? 0 : 8);
    IDLE = 1'b0;
    tick();
    check("idle_drop_valid", int'(valid_contador), 0);
    idle_cyc();

    // Repeated read of one counter.
    do_reset();
    pop_n(0, 4, 1'b0);
    rd(0, 4);
    rd(0, CLR ? 0 : 4);
    idle_cyc();
    idle_cyc();
    idle_cyc();

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
